// File: rtl/bp_pkg.sv
// Shared types and widths for the branch predictor: 2-bit counter states,
// PC/statistic widths and the saturating counter step.
package bp_pkg;

  localparam int unsigned PcW   = 32;
  localparam int unsigned StatW = 32;

  typedef enum logic [1:0] {
    Snt = 2'd0,
    Wnt = 2'd1,
    Wt  = 2'd2,
    St  = 2'd3
  } ctr_e;

  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    unique case (cur)
      Snt: nxt = taken ? Wnt : Snt;
      Wnt: nxt = taken ? Wt  : Snt;
      Wt:  nxt = taken ? St  : Wnt;
      St:  nxt = taken ? St  : Wt;
      default: nxt = Wnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_stats.sv
// Saturating resolve statistics: total, correctly predicted and mispredicted.
module bp_stats
  import bp_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             r_valid_i,
  input  logic             hit_i,
  output logic [StatW-1:0] total_o,
  output logic [StatW-1:0] hit_o,
  output logic [StatW-1:0] miss_o
);

  localparam logic [StatW-1:0] StatMax = '1;

  logic [StatW-1:0] total_q, hit_q, miss_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      total_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else if (r_valid_i) begin
      if (total_q != StatMax) total_q <= total_q + StatW'(1);
      if (hit_i && hit_q != StatMax) hit_q <= hit_q + StatW'(1);
      if (!hit_i && miss_q != StatMax) miss_q <= miss_q + StatW'(1);
    end
  end

  assign total_o = total_q;
  assign hit_o   = hit_q;
  assign miss_o  = miss_q;

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare branch predictor with direct-mapped BTB and statistics.
// Define BP_GSHARE_EN to XOR the global history into the PHT lookup index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PHT_IDX_W = 6,
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_valid,
  input  logic [PcW-1:0]       f_pc,
  output logic                 p_valid,
  output logic                 p_taken,
  output logic [PcW-1:0]       p_target,
  output logic [PHT_IDX_W-1:0] p_idx,
  input  logic                 r_valid,
  input  logic [PcW-1:0]       r_pc,
  input  logic [PHT_IDX_W-1:0] r_idx,
  input  logic                 r_taken,
  input  logic [PcW-1:0]       r_target,
  input  logic                 r_pred_taken,
  output logic [StatW-1:0]     stat_total,
  output logic [StatW-1:0]     stat_hit,
  output logic [StatW-1:0]     stat_miss
);

  localparam int unsigned PhtN = 1 << PHT_IDX_W;
  localparam int unsigned BtbN = 1 << BTB_IDX_W;
  localparam int unsigned TagW = PcW - BTB_IDX_W;

  ctr_e                 pht_q       [PhtN];
  logic                 btb_valid_q [BtbN];
  logic [TagW-1:0]      btb_tag_q   [BtbN];
  logic [PcW-1:0]       btb_tgt_q   [BtbN];

  logic [PHT_IDX_W-1:0] lkp_idx;
  logic [BTB_IDX_W-1:0] f_bidx, r_bidx;
  logic [1:0]           lkp_ctr;
  logic                 btb_hit;

  logic                 p_valid_q, p_taken_q;
  logic [PcW-1:0]       p_target_q;
  logic [PHT_IDX_W-1:0] p_idx_q;

`ifdef BP_GSHARE_EN
  logic [PHT_IDX_W-1:0] ghr_q;

  // History is only advanced by resolved branches, never speculatively.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr_q <= '0;
    else if (r_valid) ghr_q <= {ghr_q[PHT_IDX_W-2:0], r_taken};
  end

  assign lkp_idx = f_pc[PHT_IDX_W-1:0] ^ ghr_q;
`else
  assign lkp_idx = f_pc[PHT_IDX_W-1:0];
`endif

  assign f_bidx  = f_pc[BTB_IDX_W-1:0];
  assign r_bidx  = r_pc[BTB_IDX_W-1:0];
  assign lkp_ctr = pht_q[lkp_idx];
  assign btb_hit = btb_valid_q[f_bidx] && (btb_tag_q[f_bidx] == f_pc[PcW-1:BTB_IDX_W]);

  // Lookups read the registered arrays, so a same-cycle update is not yet visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PhtN; i++) pht_q[i] <= Wnt;
    end else if (r_valid) begin
      pht_q[r_idx] <= ctr_next(pht_q[r_idx], r_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BtbN; i++) btb_valid_q[i] <= 1'b0;
    end else if (r_valid && r_taken) begin
      btb_valid_q[r_bidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_valid && r_taken) begin
      btb_tag_q[r_bidx] <= r_pc[PcW-1:BTB_IDX_W];
      btb_tgt_q[r_bidx] <= r_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q  <= 1'b0;
      p_taken_q  <= 1'b0;
      p_target_q <= '0;
      p_idx_q    <= '0;
    end else begin
      p_valid_q  <= f_valid;
      p_taken_q  <= f_valid && btb_hit && lkp_ctr[1];
      p_target_q <= (f_valid && btb_hit) ? btb_tgt_q[f_bidx] : '0;
      p_idx_q    <= f_valid ? lkp_idx : '0;
    end
  end

  assign p_valid  = p_valid_q;
  assign p_taken  = p_taken_q;
  assign p_target = p_target_q;
  assign p_idx    = p_idx_q;

  bp_stats u_stats (
    .clk_i     (clk),
    .rst_i     (rst),
    .r_valid_i (r_valid),
    .hit_i     (r_pred_taken == r_taken),
    .total_o   (stat_total),
    .hit_o     (stat_hit),
    .miss_o    (stat_miss)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;

  localparam int PhtN = 64;
  localparam int BtbN = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        p_valid, p_taken;
  logic [31:0] p_target;
  logic [5:0]  p_idx;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [5:0]  r_idx;
  logic        r_taken;
  logic [31:0] r_target;
  logic        r_pred_taken;
  logic [31:0] stat_total, stat_hit, stat_miss;

  branch_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .f_valid      (f_valid),
    .f_pc         (f_pc),
    .p_valid      (p_valid),
    .p_taken      (p_taken),
    .p_target     (p_target),
    .p_idx        (p_idx),
    .r_valid      (r_valid),
    .r_pc         (r_pc),
    .r_idx        (r_idx),
    .r_taken      (r_taken),
    .r_target     (r_target),
    .r_pred_taken (r_pred_taken),
    .stat_total   (stat_total),
    .stat_hit     (stat_hit),
    .stat_miss    (stat_miss)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: counters as integers 0..3, BTB keyed by full PC.
  int          m_pht   [PhtN];
  bit          m_bv    [BtbN];
  logic [31:0] m_bpc   [BtbN];
  logic [31:0] m_btgt  [BtbN];
  int          m_ghr;
  longint      m_tot, m_hit, m_miss;
  bit          e_valid, e_taken;
  logic [31:0] e_target;
  int          e_idx;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PhtN; i++) m_pht[i] = 1;
    for (int i = 0; i < BtbN; i++) m_bv[i] = 0;
    m_ghr = 0;
    m_tot = 0; m_hit = 0; m_miss = 0;
    e_valid = 0; e_taken = 0; e_target = 0; e_idx = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_p_valid"}, 32'(p_valid), 32'(e_valid));
    check_val({tag, "_p_taken"}, 32'(p_taken), 32'(e_taken));
    if (e_valid) begin
      check_val({tag, "_p_target"}, p_target, e_target);
      check_val({tag, "_p_idx"}, 32'(p_idx), 32'(e_idx));
    end
    check_val({tag, "_stat_total"}, stat_total, m_tot[31:0]);
    check_val({tag, "_stat_hit"}, stat_hit, m_hit[31:0]);
    check_val({tag, "_stat_miss"}, stat_miss, m_miss[31:0]);
  endtask

  // One clock: drive lookup + resolve, predict from pre-update model state, then update.
  task automatic cycle(input string tag, input bit fv, input logic [31:0] fpc,
                       input bit rv, input logic [31:0] rpc, input int ridx,
                       input bit rt, input logic [31:0] rtgt, input bit rp);
    int  idx, b;
    bit  hit;
    f_valid = fv; f_pc = fpc;
    r_valid = rv; r_pc = rpc; r_idx = 6'(ridx); r_taken = rt; r_target = rtgt;
    r_pred_taken = rp;
`ifdef BP_GSHARE_EN
    idx = (int'(fpc % PhtN) ^ m_ghr) % PhtN;
`else
    idx = int'(fpc % PhtN);
`endif
    b   = int'(fpc % BtbN);
    hit = m_bv[b] && (m_bpc[b] / BtbN == fpc / BtbN);
    e_valid  = fv;
    e_taken  = fv && hit && (m_pht[idx] >= 2);
    e_target = (fv && hit) ? m_btgt[b] : 32'd0;
    e_idx    = fv ? idx : 0;
    if (rv) begin
      if (rt) m_pht[ridx % PhtN] = (m_pht[ridx % PhtN] == 3) ? 3 : m_pht[ridx % PhtN] + 1;
      else    m_pht[ridx % PhtN] = (m_pht[ridx % PhtN] == 0) ? 0 : m_pht[ridx % PhtN] - 1;
      if (rt) begin
        m_bv[rpc % BtbN]   = 1;
        m_bpc[rpc % BtbN]  = rpc;
        m_btgt[rpc % BtbN] = rtgt;
      end
      m_ghr = ((m_ghr * 2) + int'(rt)) % PhtN;
      if (m_tot < 64'hFFFF_FFFF) m_tot++;
      if (rp == rt) begin
        if (m_hit < 64'hFFFF_FFFF) m_hit++;
      end else begin
        if (m_miss < 64'hFFFF_FFFF) m_miss++;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input bit rt,
                         input logic [31:0] tgt);
    cycle(tag, 0, 0, 1, pc, int'(pc % PhtN), rt, tgt, rt);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc);
    cycle(tag, 1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset held across one rising edge while a lookup and an update are presented.
  task automatic pulse_reset(input string tag);
    f_valid = 1; f_pc = 32'h10;
    r_valid = 1; r_pc = 32'h10; r_idx = 6'h10; r_taken = 1; r_target = 32'h4;
    r_pred_taken = 0;
    rst = 1;
    model_reset();
    #1;
    check_outputs({tag, "_async"});
    @(posedge clk);
    #1;
    check_outputs({tag, "_held"});
    rst = 0;
    idle({tag, "_rel"});
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = 32'($urandom_range(0, 63));
    if ($urandom_range(0, 7) == 0) pc = pc | 32'hABCD_0000;
    return pc;
  endfunction

  initial begin
    logic [31:0] pc, rpc;
    bit          rt;
    f_valid = 0; f_pc = 0; r_valid = 0; r_pc = 0; r_idx = 0; r_taken = 0;
    r_target = 0; r_pred_taken = 0;
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 0;
    idle("post_reset");

    // First lookup after reset: valid, not taken, no target.
    lookup("cold_lookup", 32'h10);
    check_val("cold_taken", 32'(p_taken), 32'd0);
    check_val("cold_target", p_target, 32'd0);

    // Two taken resolves train BTB and counter to strongly taken.
    resolve("train_a", 32'h10, 1, 32'h4);
    resolve("train_b", 32'h10, 1, 32'h4);
    lookup("trained_lookup", 32'h10);
`ifndef BP_GSHARE_EN
    check_val("trained_taken", 32'(p_taken), 32'd1);
    check_val("trained_target", p_target, 32'h4);
`endif

    // Four taken then one not-taken leaves the counter weakly taken.
    for (int i = 0; i < 4; i++) resolve("sat_t", 32'h20, 1, 32'h80);
    resolve("sat_nt", 32'h20, 0, 32'h80);
    lookup("hyst_lookup", 32'h20);
`ifndef BP_GSHARE_EN
    check_val("hyst_taken", 32'(p_taken), 32'd1);
`endif

    // Same-cycle lookup and update on one index: lookup sees the old counter.
    cycle("btb_prime", 0, 0, 1, 32'h5, 63, 1, 32'h100, 1);
    cycle("rbw_same", 1, 32'h5, 1, 32'h7, 5, 1, 32'h200, 1);
`ifndef BP_GSHARE_EN
    check_val("rbw_old_taken", 32'(p_taken), 32'd0);
`endif
    lookup("rbw_next", 32'h5);
`ifndef BP_GSHARE_EN
    check_val("rbw_new_taken", 32'(p_taken), 32'd1);
`endif

    // Ten resolves, seven correctly predicted.
    pulse_reset("stats_rst");
    for (int i = 0; i < 10; i++) begin
      rt = 1'($urandom_range(0, 1));
      cycle("stats", 0, 0, 1, 32'h30, 48, rt, 32'h44, (i < 7) ? rt : !rt);
    end
    check_val("stats_total10", stat_total, 32'd10);
    check_val("stats_hit7", stat_hit, 32'd7);
    check_val("stats_miss3", stat_miss, 32'd3);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      pc  = rand_pc();
      rpc = rand_pc();
      cycle("rand", 1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)), rpc,
            ($urandom_range(0, 1) == 1) ? int'(rpc % PhtN) : int'($urandom_range(0, 63)),
            1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    // Mid-stream reset discards trained state.
    resolve("pre_rst_a", 32'h10, 1, 32'h4);
    resolve("pre_rst_b", 32'h10, 1, 32'h4);
    pulse_reset("mid_rst");
    check_val("mid_rst_total", stat_total, 32'd0);
    check_val("mid_rst_hit", stat_hit, 32'd0);
    check_val("mid_rst_miss", stat_miss, 32'd0);
    lookup("after_rst", 32'h10);
    check_val("after_rst_valid", 32'(p_valid), 32'd1);
    check_val("after_rst_taken", 32'(p_taken), 32'd0);
    check_val("after_rst_target", p_target, 32'd0);

    for (int i = 0; i < 500; i++) begin
      pc  = rand_pc();
      rpc = rand_pc();
      cycle("rand2", 1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)), rpc,
            int'(rpc % PhtN), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PHT_IDX_W, default 6, PHT index width (64 two-bit counters).
REQ-002 SHALL have parameter BTB_IDX_W, default 4, BTB index width (16 direct-mapped entries).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port f_valid  input  1  fetch lookup request.
REQ-006 SHALL have port f_pc  input  32  fetch PC, word address.
REQ-007 SHALL have port p_valid  output  1  prediction valid, one cycle after f_valid.
REQ-008 SHALL have port p_taken  output  1  predicted direction.
REQ-009 SHALL have port p_target  output  32  predicted target; 0 on BTB miss.
REQ-010 SHALL have port p_idx  output  PHT_IDX_W  PHT index used; carried down the pipeline to resolve.
REQ-011 SHALL have port r_valid  input  1  branch resolved in execute.
REQ-012 SHALL have ports r_pc 32, r_idx PHT_IDX_W, r_taken 1, r_target 32, r_pred_taken 1, all inputs describing the resolved branch.
REQ-013 SHALL have ports stat_total, stat_hit, stat_miss, each output 32, prediction statistics.

Function
REQ-014 SHALL register the lookup: f_valid at edge N gives p_valid/p_taken/p_target/p_idx valid after edge N+1, latency 1.
REQ-015 SHALL drive p_valid=0 and p_taken=0 in every cycle following a cycle with f_valid=0.
REQ-016 SHALL set p_taken = counter[1] at the looked-up PHT index; counter states are SNT=0, WNT=1, WT=2, ST=3.
REQ-017 SHALL report a BTB hit when entry (f_pc[BTB_IDX_W-1:0]) is valid and its tag equals f_pc[31:BTB_IDX_W]; p_target = stored target on hit, 0 otherwise; p_taken is forced 0 on BTB miss.
REQ-018 SHALL, on r_valid, increment the counter at r_idx when r_taken (saturating at ST) and decrement it otherwise (saturating at SNT).
REQ-019 SHALL, on r_valid && r_taken, write the BTB entry for r_pc with valid=1, the tag, and r_target; not-taken branches leave the BTB unchanged.
REQ-020 SHALL shift r_taken into the LSB of the global history register (GHR, width PHT_IDX_W) on each r_valid; there is no speculative GHR update.
REQ-021 SHALL use the pre-update value when a lookup and an update hit the same PHT or BTB entry in the same cycle (read-before-write).
REQ-022 SHALL, on r_valid, increment stat_total, and increment stat_hit if r_pred_taken==r_taken, else stat_miss; all counters saturate at 0xFFFF_FFFF.
REQ-023 SHALL keep stat_total == stat_hit + stat_miss at all times while unsaturated.

Reset
REQ-024 SHALL, while rst=1, set all PHT counters to WNT, clear all BTB valid bits, and set GHR=0, stats=0, p_valid=0, p_taken=0, p_target=0, p_idx=0.
REQ-025 SHALL discard any lookup or update in flight when rst asserts mid-operation; the first lookup after deassertion sees fully reset state.

Configuration
REQ-026 SHALL, with BP_GSHARE_EN defined, compute the lookup index as f_pc[PHT_IDX_W-1:0] XOR GHR.
REQ-027 SHALL, without BP_GSHARE_EN, compute the index as f_pc[PHT_IDX_W-1:0] (bimodal); the GHR is then removed.

Structure
REQ-028 SHALL take the counter-state enum (SNT/WNT/WT/ST), the PC width of 32 and the stat width of 32 from shared package bp_pkg.
REQ-029 SHALL implement the three saturating statistic counters in the sub-module bp_stats (inputs: r_valid and the hit flag).

Verification
REQ-030 SHALL cover: reset, then f_valid with f_pc=0x10 -> next cycle p_valid=1, p_taken=0, p_target=0.
REQ-031 SHALL cover: two resolves of r_pc=0x10 with r_taken=1 and r_target=0x4, then a lookup of 0x10 -> p_taken=1 and p_target=0x4 (bimodal build).
REQ-032 SHALL cover: four taken resolves followed by one not-taken on the same index -> counter reads WT, so the prediction is still taken.
REQ-033 SHALL cover: a same-cycle lookup and update on one index starting from WNT -> the lookup returns not-taken and the next lookup returns taken.
REQ-034 SHALL cover: 10 resolves with 7 matching r_pred_taken -> stat_total=10, stat_hit=7, stat_miss=3.
REQ-035 SHALL cover: rst asserted for one cycle mid-stream with the BTB populated -> all stats 0, and a lookup of the previously trained PC returns p_taken=0 and p_target=0.
